// File: rtl/pixel_sink.sv
// Pixel plot target: 2-stage plot write path into a SCREEN_W x SCREEN_H framebuffer,
// saturating accept/discard counters, and a start/done raster readback scanner.
module pixel_sink #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          vga_x,
  input  logic [6:0]          vga_y,
  input  logic [COLOUR_W-1:0] vga_colour,
  input  logic                vga_plot,
  input  logic                scan_start,
  output logic                scan_valid,
  output logic [7:0]          scan_x,
  output logic [6:0]          scan_y,
  output logic [COLOUR_W-1:0] scan_colour,
  output logic                scan_done,
  output logic [15:0]         plot_count,
  output logic [15:0]         oob_count
);
  localparam int         DEPTH  = SCREEN_W * SCREEN_H;
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {SCAN_IDLE, SCAN_RUN, SCAN_FLUSH, SCAN_DONE} scan_state_e;

  logic [COLOUR_W-1:0] mem [DEPTH];

  // vld_pipe_q[0] is the S1 plot flag, vld_pipe_q[1] the S2 plot flag
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  logic [7:0]          s1_x_q, s1_x_d;
  logic [6:0]          s1_y_q, s1_y_d;
  logic [COLOUR_W-1:0] s1_c_q, s1_c_d, s2_c_q, s2_c_d;
  logic                s2_inr_q, s2_inr_d;
  logic [14:0]         s2_addr_q, s2_addr_d;
  logic [15:0]         plot_cnt_q, plot_cnt_d, oob_cnt_q, oob_cnt_d;
  logic                wr_en;

  scan_state_e         state_q, state_d;
  logic [7:0]          cx_q, cx_d, sx_q, sx_d;
  logic [6:0]          cy_q, cy_d, sy_q, sy_d;
  logic                svld_q, svld_d;
  logic [COLOUR_W-1:0] rd_colour_q;
  logic [14:0]         rd_addr;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], vga_plot};
    s1_x_d     = vga_x;
    s1_y_d     = vga_y;
    s1_c_d     = vga_colour;
    s2_c_d     = s1_c_q;
    s2_inr_d   = (32'(s1_x_q) < SCREEN_W) && (32'(s1_y_q) < SCREEN_H);
    s2_addr_d  = 15'(32'(s1_y_q) * SCREEN_W + 32'(s1_x_q));
    wr_en      = vld_pipe_q[1] && s2_inr_q;
    plot_cnt_d = plot_cnt_q;
    oob_cnt_d  = oob_cnt_q;
    if (vld_pipe_q[1]) begin
      if (s2_inr_q) begin
        if (plot_cnt_q != 16'hFFFF) plot_cnt_d = plot_cnt_q + 16'd1;
      end else if (oob_cnt_q != 16'hFFFF) begin
        oob_cnt_d = oob_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    svld_d  = 1'b0;
    rd_addr = 15'(32'(cy_q) * SCREEN_W + 32'(cx_q));
    case (state_q)
      SCAN_IDLE: begin
        cx_d = '0;
        cy_d = '0;
        if (scan_start) state_d = SCAN_RUN;
      end
      SCAN_RUN: begin
        svld_d = 1'b1;
        sx_d   = cx_q;
        sy_d   = cy_q;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d    = '0;
            state_d = SCAN_FLUSH;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      SCAN_FLUSH: state_d = SCAN_DONE;
      SCAN_DONE:  if (!scan_start) state_d = SCAN_IDLE;
      default:    state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_c_q     <= '0;
      s2_c_q     <= '0;
      s2_inr_q   <= 1'b0;
      s2_addr_q  <= '0;
      plot_cnt_q <= '0;
      oob_cnt_q  <= '0;
      state_q    <= SCAN_IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      svld_q     <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_c_q     <= s1_c_d;
      s2_c_q     <= s2_c_d;
      s2_inr_q   <= s2_inr_d;
      s2_addr_q  <= s2_addr_d;
      plot_cnt_q <= plot_cnt_d;
      oob_cnt_q  <= oob_cnt_d;
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      svld_q     <= svld_d;
    end
  end

  // Read-first RAM: the read samples the array before this edge's write lands.
  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[s2_addr_q] <= s2_c_q;
    if (rst) rd_colour_q <= '0;
    else if (state_q == SCAN_RUN) rd_colour_q <= mem[rd_addr];
  end

  assign scan_valid  = svld_q;
  assign scan_x      = sx_q;
  assign scan_y      = sy_q;
  assign scan_colour = rd_colour_q;
  assign scan_done   = (state_q == SCAN_DONE);
  assign plot_count  = plot_cnt_q;
  assign oob_count   = oob_cnt_q;
endmodule

// File: doc/pixel_sink.md
# pixel_sink

Receiving end of the pixel plot interface driven by the fill/draw FSMs. Captures every `vga_plot` strobe into an internal 160x120 framebuffer, discards and counts off-screen writes, and provides a start/done raster readback scanner so a bench or downstream block can stream the stored image back out. It sits where the VGA adapter would sit, as a cycle-accurate, inspectable pixel target.

## Interface
Parameters:
- `SCREEN_W`, 160, visible columns (x range 0..SCREEN_W-1)
- `SCREEN_H`, 120, visible rows (y range 0..SCREEN_H-1)
- `COLOUR_W`, 3, colour bits per pixel

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `vga_x`  in  8  plot column
- `vga_y`  in  7  plot row
- `vga_colour`  in  COLOUR_W  plot colour
- `vga_plot`  in  1  plot strobe, one pixel per cycle while high, no backpressure
- `scan_start`  in  1  level request for a full readback scan
- `scan_valid`  out  1  `scan_x`/`scan_y`/`scan_colour` valid this cycle
- `scan_x`  out  8  column of the returned pixel
- `scan_y`  out  7  row of the returned pixel
- `scan_colour`  out  COLOUR_W  stored colour
- `scan_done`  out  1  scan complete, held until `scan_start` low
- `plot_count`  out  16  accepted in-range plots, saturates at 16'hFFFF
- `oob_count`  out  16  discarded out-of-range plots, saturates at 16'hFFFF

## Operation
- Write path, 2 stages. S1 registers x, y, colour and plot. S2 checks range: in range means x < SCREEN_W and y < SCREEN_H. In-range plots write mem[addr] and increment `plot_count`. Out-of-range plots do not write and increment `oob_count`.
- addr = y*SCREEN_W + x, 15 bits. For the default size, (y<<7)+(y<<5)+x. Maximum 19199.
- Framebuffer is one write port plus one synchronous read port, read-first: a read of an address written in the same cycle returns the old value. Contents are not cleared by `rst`.
- Scan FSM states are SCAN_IDLE, SCAN_RUN, SCAN_FLUSH and SCAN_DONE:
  - SCAN_IDLE: read counters held at (0,0). Goes to SCAN_RUN when `scan_start`=1.
  - SCAN_RUN: issues one read per cycle in raster order, x fastest: (0,0),(1,0)..(159,0),(0,1)..(159,119). Goes to SCAN_FLUSH after issuing (159,119).
  - SCAN_FLUSH: one cycle in which the last read data returns. Then goes to SCAN_DONE.
  - SCAN_DONE: `scan_done`=1. Goes to SCAN_IDLE when `scan_start`=0.
- Read coordinates are delayed one cycle so `scan_x`/`scan_y` align with `scan_colour`.
- Plotting continues freely during a scan. A pixel read returns any write that completed in S2 on an earlier cycle.
- Default state for illegal encodings is SCAN_IDLE.

## Timing
- Reset values: `scan_valid`=0, `scan_done`=0, `scan_x`=0, `scan_y`=0, `scan_colour`=0, `plot_count`=0, `oob_count`=0, FSM in SCAN_IDLE, S1/S2 plot flags cleared.
- Write latency: a plot sampled at edge T is written at edge T+2. A read issued at edge T+2 or later sees it.
- Counters update at edge T+2 for a plot sampled at T.
- Scan length: `scan_start` high at edge T puts the FSM in SCAN_RUN at T+1. The first read is issued at T+1, and the first `scan_valid` comes at T+2. There are exactly 19200 consecutive `scan_valid` cycles. `scan_done` rises the cycle after the last valid.
- `scan_start` dropped mid-scan is ignored; the scan always completes.
- `rst` mid-scan returns to SCAN_IDLE next cycle, drops `scan_valid`, and discards in-flight plots in S1/S2.
- Both counters saturate; they never wrap.

## Test plan
- Reset, then plot (5,3) with colour 3'b101, then run a scan. Required: `scan_valid` with x=5,y=3 shows colour 101; `plot_count`=1; `oob_count`=0.
- Plot (160,0), (0,120) and (255,127). Required: `oob_count`=3, `plot_count`=0, no framebuffer change (a scan returns pre-test contents).
- Full 160x120 fill with colour 3'b010, y fastest, 19200 cycles of `vga_plot`. Required: `plot_count`=19200, and the scan returns 010 for all 19200 pixels in raster order.
- Raise `scan_start` and count cycles. Required: first `scan_valid` 2 cycles after the start edge; exactly 19200 valids; `scan_done` high the cycle after; `scan_done` falls one cycle after `scan_start` goes 0.
- Plot address 0 with colour 7 on the same cycle the scan reads address 0. Required: old value returned (read-first). A second scan returns 7.
- Assert `rst` at scan pixel 1000 with a plot in flight. Required: `scan_valid`=0 next cycle, counters 0, in-flight pixel not written.
